// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage driving a req/ack data-memory port.
// Ports: clk/rst (async active-low); EXEMEM_* instruction fields from EXE/MEM;
// dm_* registered memory request, dm_ack/dm_rdata completion; stall holds EXE/MEM;
// MEMWB_* registered results to MEM/WB; mem_exc {bus_err, misalign} pulses.
module mem_access_stage #(
  parameter int ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] EXEMEM_pc,
  input  logic [4:0]  EXEMEM_rd,
  input  logic [1:0]  EXEMEM_toReg,
  input  logic [3:0]  EXEMEM_DMRd,
  input  logic [1:0]  EXEMEM_DMWr,
  input  logic        EXEMEM_RFWr,
  input  logic [31:0] EXEMEM_DMdata,
  input  logic [31:0] EXEMEM_ALUout,
  output logic        dm_req,
  output logic        dm_we,
  output logic [3:0]  dm_be,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  output logic        stall,
  output logic [31:0] MEMWB_pc,
  output logic [4:0]  MEMWB_rd,
  output logic [1:0]  MEMWB_toReg,
  output logic        MEMWB_RFWr,
  output logic [31:0] MEMWB_DMout,
  output logic [31:0] MEMWB_ALUout,
  output logic [1:0]  mem_exc
);
  localparam logic [3:0] DMRD_NOP = 4'd0, DMRD_LW = 4'd1, DMRD_LH = 4'd2, DMRD_LHU = 4'd3, DMRD_LB = 4'd4, DMRD_LBU = 4'd5;
  localparam logic [1:0] DMWR_NOP = 2'd0, DMWR_SW = 2'd1, DMWR_SH = 2'd2, DMWR_SB = 2'd3;
  localparam logic [1:0] ALU2REG = 2'd0;
  localparam int CW = $clog2(ACK_TIMEOUT + 1);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        dm_req_q, dm_req_d, dm_we_q, dm_we_d;
  logic [3:0]  dm_be_q, dm_be_d;
  logic [31:0] dm_addr_q, dm_addr_d, dm_wdata_q, dm_wdata_d;
  logic [31:0] pc_q, pc_d, dmout_q, dmout_d, alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic [1:0]  to_reg_q, to_reg_d, exc_q, exc_d;
  logic        rfwr_q, rfwr_d;
  logic        is_st, memop, misalign, start, timeout;
  logic [1:0]  a;
  logic [7:0]  b;
  logic [15:0] h;
  logic [3:0]  be;
  logic [31:0] wdata, ld;
  always_comb begin
    a        = EXEMEM_ALUout[1:0];
    is_st    = EXEMEM_DMWr != DMWR_NOP;
    memop    = is_st || EXEMEM_DMRd != DMRD_NOP;
    misalign = is_st ? ((EXEMEM_DMWr == DMWR_SW && a != 2'b00) || (EXEMEM_DMWr == DMWR_SH && a[0]))
                     : ((EXEMEM_DMRd == DMRD_LW && a != 2'b00) ||
                        ((EXEMEM_DMRd == DMRD_LH || EXEMEM_DMRd == DMRD_LHU) && a[0]));
    start    = state_q == IDLE && memop && !misalign;
    timeout  = state_q == ACCESS && !dm_ack && cnt_q == CW'(ACK_TIMEOUT);
    be       = !is_st ? 4'b1111 : EXEMEM_DMWr == DMWR_SW ? 4'b1111 :
               EXEMEM_DMWr == DMWR_SH ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
    wdata    = EXEMEM_DMWr == DMWR_SW ? EXEMEM_DMdata :
               EXEMEM_DMWr == DMWR_SH ? {2{EXEMEM_DMdata[15:0]}} :
               EXEMEM_DMWr == DMWR_SB ? {4{EXEMEM_DMdata[7:0]}} : 32'd0;
    b        = dm_rdata[{a, 3'b000} +: 8];
    h        = a[1] ? dm_rdata[31:16] : dm_rdata[15:0];
    ld       = is_st ? 32'd0 :
               EXEMEM_DMRd == DMRD_LW  ? dm_rdata :
               EXEMEM_DMRd == DMRD_LH  ? {{16{h[15]}}, h} :
               EXEMEM_DMRd == DMRD_LHU ? {16'd0, h} :
               EXEMEM_DMRd == DMRD_LB  ? {{24{b[7]}}, b} :
               EXEMEM_DMRd == DMRD_LBU ? {24'd0, b} : 32'd0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_be_q    <= 4'd0;
      dm_addr_q  <= 32'd0;
      dm_wdata_q <= 32'd0;
      pc_q       <= 32'd0;
      rd_q       <= 5'd0;
      to_reg_q   <= ALU2REG;
      rfwr_q     <= 1'b0;
      dmout_q    <= 32'd0;
      alu_q      <= 32'd0;
      exc_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_be_q    <= dm_be_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      pc_q       <= pc_d;
      rd_q       <= rd_d;
      to_reg_q   <= to_reg_d;
      rfwr_q     <= rfwr_d;
      dmout_q    <= dmout_d;
      alu_q      <= alu_d;
      exc_q      <= exc_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (start) state_d = ACCESS;
    else if (state_q == ACCESS && (dm_ack || timeout)) state_d = IDLE;
  end
  // IDLE writes MEM/WB every cycle (instruction or bubble); ACCESS holds it until
  // completion, relying on the EXE/MEM register holding the instruction meanwhile.
  always_comb begin
    cnt_d      = cnt_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_be_d    = dm_be_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    pc_d       = pc_q;
    rd_d       = rd_q;
    to_reg_d   = to_reg_q;
    rfwr_d     = rfwr_q;
    dmout_d    = dmout_q;
    alu_d      = alu_q;
    exc_d      = 2'd0;
    stall      = 1'b0;
    if (state_q == IDLE) begin
      stall    = start;
      pc_d     = EXEMEM_pc;
      to_reg_d = EXEMEM_toReg;
      alu_d    = EXEMEM_ALUout;
      rd_d     = memop ? 5'd0 : EXEMEM_rd;
      rfwr_d   = memop ? 1'b0 : EXEMEM_RFWr;
      dmout_d  = 32'd0;
      exc_d[0] = memop && misalign;
      if (start) begin
        cnt_d      = CW'(1);
        dm_req_d   = 1'b1;
        dm_we_d    = is_st;
        dm_be_d    = be;
        dm_addr_d  = {EXEMEM_ALUout[31:2], 2'b00};
        dm_wdata_d = wdata;
      end
    end else if (dm_ack || timeout) begin
      cnt_d    = '0;
      dm_req_d = 1'b0;
      pc_d     = EXEMEM_pc;
      to_reg_d = EXEMEM_toReg;
      alu_d    = EXEMEM_ALUout;
      rd_d     = dm_ack ? EXEMEM_rd : 5'd0;
      rfwr_d   = dm_ack ? EXEMEM_RFWr : 1'b0;
      dmout_d  = dm_ack ? ld : 32'd0;
      exc_d[1] = timeout;
    end else begin
      stall = 1'b1;
      cnt_d = cnt_q + CW'(1);
    end
  end
  assign dm_req       = dm_req_q;
  assign dm_we        = dm_we_q;
  assign dm_be        = dm_be_q;
  assign dm_addr      = dm_addr_q;
  assign dm_wdata     = dm_wdata_q;
  assign MEMWB_pc     = pc_q;
  assign MEMWB_rd     = rd_q;
  assign MEMWB_toReg  = to_reg_q;
  assign MEMWB_RFWr   = rfwr_q;
  assign MEMWB_DMout  = dmout_q;
  assign MEMWB_ALUout = alu_q;
  assign mem_exc      = exc_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench for mem_access_stage with directed vectors.
module tb_mem_access_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc, dmdata, aluout, dm_rdata;
  logic [4:0]  rd;
  logic [1:0]  to_reg, dmwr;
  logic [3:0]  dmrd;
  logic        rfwr, dm_ack;
  logic        dm_req, dm_we, stall, wb_rfwr;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr, dm_wdata, wb_pc, wb_dmout, wb_alu;
  logic [4:0]  wb_rd;
  logic [1:0]  wb_to, mem_exc;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] pc; logic [4:0] rd; logic [1:0] to; logic rf; logic [31:0] alu; logic [31:0] dmo; logic [1:0] exc;} ret_t;
  typedef struct {logic we; logic [3:0] be; logic [31:0] addr; logic [31:0] wdata;} req_t;
  ret_t rq[$];
  req_t qq[$];
  req_t cur;
  ret_t e;
  logic pend = 1'b0, req_prev = 1'b0;
  mem_access_stage #(.ACK_TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .EXEMEM_pc(pc), .EXEMEM_rd(rd), .EXEMEM_toReg(to_reg), .EXEMEM_DMRd(dmrd),
    .EXEMEM_DMWr(dmwr), .EXEMEM_RFWr(rfwr), .EXEMEM_DMdata(dmdata), .EXEMEM_ALUout(aluout),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
    .MEMWB_pc(wb_pc), .MEMWB_rd(wb_rd), .MEMWB_toReg(wb_to), .MEMWB_RFWr(wb_rfwr),
    .MEMWB_DMout(wb_dmout), .MEMWB_ALUout(wb_alu), .mem_exc(mem_exc)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // Monitor: retirements are flagged when stall is low with a tracked instruction
  // pending, and checked on the following negedge; new requests pop the request queue.
  always @(negedge clk) begin
    if (pend) begin
      e = rq.pop_front();
      chk("wb_pc", wb_pc, e.pc);
      chk("wb_rd", {27'd0, wb_rd}, {27'd0, e.rd});
      chk("wb_toReg", {30'd0, wb_to}, {30'd0, e.to});
      chk("wb_RFWr", {31'd0, wb_rfwr}, {31'd0, e.rf});
      chk("wb_ALUout", wb_alu, e.alu);
      chk("wb_DMout", wb_dmout, e.dmo);
      chk("mem_exc", {30'd0, mem_exc}, {30'd0, e.exc});
    end
    pend = rst && !stall && rq.size() > 0;
    if (dm_req && !req_prev) begin
      if (qq.size() == 0) chk("unexpected_req", {31'd0, dm_req}, 32'd0);
      else begin
        cur = qq.pop_front();
        chk("dm_we", {31'd0, dm_we}, {31'd0, cur.we});
        chk("dm_be", {28'd0, dm_be}, {28'd0, cur.be});
        chk("dm_addr", dm_addr, cur.addr);
        chk("dm_wdata", dm_wdata, cur.wdata);
      end
    end else if (dm_req) begin
      chk("dm_addr_hold", dm_addr, cur.addr);
      chk("dm_be_hold", {28'd0, dm_be}, {28'd0, cur.be});
    end
    req_prev = dm_req;
  end
  task automatic nop();
    pc = 0; rd = 0; to_reg = 0; dmrd = 0; dmwr = 0; rfwr = 0; dmdata = 0; aluout = 0;
  endtask
  task automatic issue(input logic [31:0] ipc, input logic [4:0] ird, input logic [1:0] itr,
                       input logic [3:0] irdt, input logic [1:0] iwrt, input logic irf,
                       input logic [31:0] idata, input logic [31:0] ialu, input int ack_after,
                       input logic [31:0] irdata, input logic [31:0] exp_dmo, input logic [1:0] exp_exc,
                       input logic exp_req, input logic [3:0] exp_be, input logic [31:0] exp_wd,
                       input int exp_stall, input int exp_reqc, input string nm);
    ret_t r;
    req_t q;
    int stalls = 0, acc = 0, reqc = 0;
    logic done = 1'b0;
    r.pc = ipc; r.to = itr; r.alu = ialu; r.dmo = exp_dmo; r.exc = exp_exc;
    r.rd = exp_exc != 0 ? 5'd0 : ird;
    r.rf = exp_exc != 0 ? 1'b0 : irf;
    rq.push_back(r);
    if (exp_req) begin
      q.we = iwrt != 0; q.be = exp_be; q.addr = {ialu[31:2], 2'b00}; q.wdata = exp_wd;
      qq.push_back(q);
    end
    pc = ipc; rd = ird; to_reg = itr; dmrd = irdt; dmwr = iwrt; rfwr = irf; dmdata = idata; aluout = ialu;
    dm_rdata = irdata;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (dm_req) reqc++;
      if (!stall) done = 1'b1;
      else begin
        stalls++;
        @(posedge clk); #1;
        if (dm_req) begin
          acc++;
          dm_ack = acc == ack_after + 1;
        end
      end
    end
    if (!done) chk({nm, "_retire_timeout"}, 32'd0, 32'd1);
    @(posedge clk); #1;
    dm_ack = 1'b0;
    nop();
    chk({nm, "_stall_cycles"}, stalls, exp_stall);
    chk({nm, "_req_cycles"}, reqc, exp_reqc);
    @(negedge clk);
    @(negedge clk);
    chk({nm, "_exc_pulse_end"}, {30'd0, mem_exc}, 32'd0);
    chk({nm, "_req_dropped"}, {31'd0, dm_req}, 32'd0);
    @(posedge clk); #1;
  endtask
  initial begin
    rst = 1'b0; dm_ack = 1'b0; dm_rdata = 0;
    nop();
    #3;
    chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
    chk("rst_dm_be", {28'd0, dm_be}, 32'd0);
    chk("rst_dm_addr", dm_addr, 32'd0);
    chk("rst_wb_toReg", {30'd0, wb_to}, 32'd0);
    chk("rst_mem_exc", {30'd0, mem_exc}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1;
    issue(32'h40, 5, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 2'b00, 0, 4'h0, 0, 0, 0, "alu");
    issue(32'h44, 6, 1, 4, 0, 1, 0, 32'h1003, 0, 32'h80FFFFFF, 32'hFFFFFF80, 2'b00, 1, 4'hF, 0, 1, 1, "lb");
    issue(32'h48, 0, 0, 0, 2, 0, 32'hABCD, 32'h2002, 3, 0, 0, 2'b00, 1, 4'b1100, 32'hABCDABCD, 4, 4, "sh");
    issue(32'h4C, 8, 1, 1, 0, 1, 0, 32'h3001, 0, 0, 0, 2'b01, 0, 4'h0, 0, 0, 0, "lw_mis");
    issue(32'h50, 7, 1, 1, 0, 1, 0, 32'h3000, 100, 0, 0, 2'b10, 1, 4'hF, 0, 4, 4, "lw_timeout");
    issue(32'h54, 9, 1, 3, 0, 1, 0, 32'h2006, 1, 32'h87654321, 32'h00008765, 2'b00, 1, 4'hF, 0, 2, 2, "lhu");
    issue(32'h58, 10, 1, 2, 0, 1, 0, 32'h2004, 0, 32'h12348765, 32'hFFFF8765, 2'b00, 1, 4'hF, 0, 1, 1, "lh");
    issue(32'h5C, 11, 1, 5, 0, 1, 0, 32'h1001, 0, 32'h0000A500, 32'h000000A5, 2'b00, 1, 4'hF, 0, 1, 1, "lbu");
    issue(32'h60, 0, 0, 0, 3, 0, 32'h12345677, 32'h0102, 2, 0, 0, 2'b00, 1, 4'b0100, 32'h77777777, 3, 3, "sb");
    issue(32'h64, 0, 0, 0, 1, 0, 32'hDEADBEEF, 32'h0204, 0, 0, 0, 2'b00, 1, 4'hF, 32'hDEADBEEF, 1, 1, "sw");
    issue(32'h68, 12, 1, 1, 0, 1, 0, 32'h0008, 0, 32'hCAFEF00D, 32'hCAFEF00D, 2'b00, 1, 4'hF, 0, 1, 1, "lw");
    issue(32'h6C, 0, 0, 0, 2, 0, 32'h1, 32'h0001, 0, 0, 0, 2'b01, 0, 4'h0, 0, 0, 0, "sh_mis");
    issue(32'h70, 0, 0, 0, 1, 0, 32'h1, 32'h0202, 0, 0, 0, 2'b01, 0, 4'h0, 0, 0, 0, "sw_mis");
    issue(32'h74, 13, 1, 1, 1, 1, 32'h55AA55AA, 32'h0010, 0, 32'hFFFFFFFF, 0, 2'b00, 1, 4'hF, 32'h55AA55AA, 1, 1, "store_prio");
    issue(32'h78, 14, 2, 0, 0, 1, 0, 32'h7FFC, 0, 0, 0, 2'b00, 0, 4'h0, 0, 0, 0, "pc2reg");
    begin
      req_t q;
      q.we = 1'b0; q.be = 4'hF; q.addr = 32'h3000; q.wdata = 0;
      qq.push_back(q);
      pc = 32'h80; rd = 3; to_reg = 1; dmrd = 1; rfwr = 1; aluout = 32'h3000;
      @(posedge clk); @(posedge clk); #3;
      chk("pre_rst_req", {31'd0, dm_req}, 32'd1);
      rst = 1'b0; #1;
      chk("midrst_dm_req", {31'd0, dm_req}, 32'd0);
      chk("midrst_dm_we_be", {27'd0, dm_we, dm_be}, 32'd0);
      chk("midrst_dm_addr", dm_addr, 32'd0);
      chk("midrst_dm_wdata", dm_wdata, 32'd0);
      chk("midrst_wb_pc", wb_pc, 32'd0);
      chk("midrst_wb_rd_rf", {26'd0, wb_rd, wb_rfwr}, 32'd0);
      chk("midrst_wb_dmout", wb_dmout, 32'd0);
      chk("midrst_wb_alu", wb_alu, 32'd0);
      chk("midrst_wb_toReg", {30'd0, wb_to}, 32'd0);
      chk("midrst_mem_exc", {30'd0, mem_exc}, 32'd0);
      nop();
      @(posedge clk); #1 rst = 1'b1;
      repeat (3) @(negedge clk);
      chk("postrst_no_wb", {31'd0, wb_rfwr}, 32'd0);
      chk("postrst_no_req", {31'd0, dm_req}, 32'd0);
    end
    chk("retire_queue_empty", rq.size(), 32'd0);
    chk("req_queue_empty", qq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 255, giving the maximum ACCESS cycles to wait for dm_ack before a bus error.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port EXEMEM_pc  input  32  pc of instruction in EXE/MEM register.
REQ-005 SHALL have port EXEMEM_rd  input  5  destination register.
REQ-006 SHALL have port EXEMEM_toReg  input  2  writeback select (PC2Reg/Mem2Reg/ALU2Reg defines).
REQ-007 SHALL have port EXEMEM_DMRd  input  4  load type (DMRd_NOP/LW/LH/LHU/LB/LBU defines).
REQ-008 SHALL have port EXEMEM_DMWr  input  2  store type (DMWr_NOP/SW/SH/SB defines).
REQ-009 SHALL have port EXEMEM_RFWr  input  1  register-file write enable.
REQ-010 SHALL have port EXEMEM_DMdata  input  32  store data (rt value).
REQ-011 SHALL have port EXEMEM_ALUout  input  32  ALU result / effective byte address.
REQ-012 SHALL have port dm_req  output  1  data-memory request, registered.
REQ-013 SHALL have port dm_we  output  1  1 = write, 0 = read.
REQ-014 SHALL have port dm_be  output  4  byte-lane enables, little-endian.
REQ-015 SHALL have port dm_addr  output  32  word address {ALUout[31:2],2'b00}.
REQ-016 SHALL have port dm_wdata  output  32  lane-replicated store data.
REQ-017 SHALL have port dm_ack  input  1  memory completion, sampled at rising edge.
REQ-018 SHALL have port dm_rdata  input  32  read word, valid with dm_ack.
REQ-019 SHALL have port stall  output  1  combinational; 1 = EXE/MEM register must hold.
REQ-020 SHALL have ports MEMWB_pc/rd/toReg/RFWr  output  32/5/2/1  registered copies to MEM/WB.
REQ-021 SHALL have port MEMWB_DMout  output  32  aligned, extended load data.
REQ-022 SHALL have port MEMWB_ALUout  output  32  registered ALUout.
REQ-023 SHALL have port mem_exc  output  2  {bus_err, misalign}, one-cycle registered pulses.

Function
REQ-024 SHALL implement FSM IDLE/ACCESS; memop = DMWr!=NOP or DMRd!=NOP; DMWr takes priority when both non-NOP (treated as store).
REQ-025 SHALL, for a non-memop in IDLE, register inputs to MEMWB_* at the next edge (latency 1), stall=0, DMout=0.
REQ-026 SHALL, for an aligned memop in IDLE, keep stall=1, go to ACCESS at next edge, registering dm_req=1, dm_we, dm_be, dm_addr, dm_wdata, and write a bubble (RFWr=0, rd=0) to MEMWB.
REQ-027 SHALL hold dm_req and all dm_* stable in ACCESS until the dm_ack edge; stall = !dm_ack in ACCESS.
REQ-028 SHALL, on dm_ack in ACCESS, drop dm_req, write the instruction and extracted load data to MEMWB_*, and return to IDLE (minimum memop latency 2 cycles).
REQ-029 SHALL encode stores: SW be=1111; SH be=0011 (addr[1]=0) / 1100, wdata {2{DMdata[15:0]}}; SB be=0001<<addr[1:0], wdata {4{DMdata[7:0]}}; loads be=1111, we=0.
REQ-030 SHALL extract loads by addr[1:0] lane: LB/LH sign-extend, LBU/LHU zero-extend, LW full word.
REQ-031 SHALL treat LW/SW with addr[1:0]!=0 and LH/LHU/SH with addr[0]=1 as misaligned: no request, stall=0, MEMWB bubble, mem_exc[0] pulses next cycle.
REQ-032 SHALL count ACCESS cycles from 1; on reaching ACK_TIMEOUT without dm_ack, drop dm_req, write MEMWB bubble, pulse mem_exc[1], return to IDLE with stall=0 that cycle.

Reset
REQ-033 SHALL, while rst=0, immediately force IDLE, counter 0, dm_req/dm_we/dm_be/dm_addr/dm_wdata 0, mem_exc 0, MEMWB_pc/rd/RFWr/DMout/ALUout 0, MEMWB_toReg ALU2Reg; reset mid-ACCESS abandons the access with no MEMWB write.

Verification
REQ-034 ALU op pc=0x40 rd=5 ALUout=0x1234 -> next edge MEMWB_rd=5, RFWr=1, ALUout=0x1234, stall never 1.
REQ-035 LB ALUout=0x1003, ack first ACCESS cycle, rdata=0x80FF_FF_FF -> dm_addr=0x1000, DMout=0xFFFFFF80, latency 2.
REQ-036 SH ALUout=0x2002 DMdata=0xABCD, ack after 3 cycles -> be=1100, wdata=0xABCDABCD, stall=1 for 4 cycles.
REQ-037 LW ALUout=0x3001 -> dm_req never 1, mem_exc=01 one cycle, MEMWB_RFWr=0.
REQ-038 LW, ACK_TIMEOUT=4, no ack -> dm_req high 4 cycles, mem_exc=10 one cycle, stall released.
REQ-039 rst=0 asserted mid-ACCESS between edges -> dm_req=0 immediately, all outputs at reset values.
